// File: rtl/timestamp_timer_nios2_oci_dct_capture.sv
// Nios II OCI DCT trace capture: armed FIFO capture, valid/ready drain, end-of-test sequencing.
// Optional per-word timestamp when DCT_CAPTURE_TIMESTAMP_EN is defined.
module timestamp_timer_nios2_oci_dct_capture #(
  parameter int DCT_W = 30,
  parameter int CNT_W = 4,
  parameter int DEPTH = 16,
  parameter int TS_W  = 32,
`ifdef DCT_CAPTURE_TIMESTAMP_EN
  localparam int DATA_W = TS_W + CNT_W + DCT_W,
`else
  localparam int DATA_W = CNT_W + DCT_W + 0 * TS_W,
`endif
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              arm,
  input  logic [DCT_W-1:0]  dct_buffer,
  input  logic [CNT_W-1:0]  dct_count,
  input  logic              dct_wr,
  input  logic              test_ending,
  input  logic              test_has_ended,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [AW:0]       fill_level,
  output logic [15:0]       drop_count,
  output logic [1:0]        capture_state,
  output logic              done
);

  typedef enum logic [1:0] {IDLE = 2'b00, CAPTURE = 2'b01, DRAIN = 2'b10, DONE = 2'b11} state_t;

  state_t            state, state_nxt;
  logic [AW:0]       wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] wdata;
  logic              ended_seen, arm_go;
  logic              full, empty, wr_try, push, drop, pop;

  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty  = (wr_ptr == rd_ptr);
  assign wr_try = (state == CAPTURE) && dct_wr && (dct_count != '0);
  assign push   = wr_try && !full;
  assign drop   = wr_try && full;
  assign pop    = rd_valid && rd_ready;
  assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};

`ifdef DCT_CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0] ts;
  always_ff @(posedge clk) begin
    if (!reset_n) ts <= '0;
    else          ts <= ts + 1'b1;
  end
  assign wdata = {ts, dct_count, dct_buffer};
`else
  assign wdata = {dct_count, dct_buffer};
`endif

  always_comb begin
    state_nxt = state;
    arm_go    = 1'b0;
    case (state)
      IDLE:    if (arm) begin state_nxt = CAPTURE; arm_go = 1'b1; end
      CAPTURE: if (test_ending || test_has_ended) state_nxt = DRAIN;
      DRAIN:   if ((ended_seen || test_has_ended) && empty) state_nxt = DONE;
      DONE:    if (arm) begin state_nxt = CAPTURE; arm_go = 1'b1; end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      ended_seen <= 1'b0;
      drop_count <= '0;
    end else begin
      state <= state_nxt;
      if (arm_go)              ended_seen <= 1'b0;
      else if (test_has_ended) ended_seen <= 1'b1;
      if (arm_go && state == DONE)    drop_count <= '0;
      else if (drop && !(&drop_count)) drop_count <= drop_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Output stage prefetches the head after this edge's pop, so back-to-back
  // pops run without bubbles while a fresh write into an empty FIFO costs one extra edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr   <= rd_ptr_nxt;
      rd_valid <= (wr_ptr != rd_ptr_nxt);
      if (wr_ptr != rd_ptr_nxt) rd_data <= mem[rd_ptr_nxt[AW-1:0]];
    end
  end

  assign fill_level    = wr_ptr - rd_ptr;
  assign capture_state = state;
  assign done          = (state == DONE);

endmodule
